// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART TX byte port among N_SRC sources.
// A stall watchdog reclaims the grant from an owner that goes quiet mid-message.
module uart_tx_arbiter #(
    parameter int  N_SRC   = 4,
    parameter int  TIMEOUT = 255,
    localparam int SRC_W   = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     i_req,
    input  logic [8*N_SRC-1:0]   i_data,
    input  logic [N_SRC-1:0]     i_last,
    output logic [N_SRC-1:0]     o_cts,
    output logic [7:0]           o_data,
    output logic                 o_req,
    input  logic                 i_cts,
    input  logic                 i_idle,
    output logic [N_SRC-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic [15:0]          o_msg_count
);
    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

    state_t               r_state;
    logic [SRC_W-1:0]     r_gidx;
    logic [SRC_W-1:0]     r_last_winner;
    logic [15:0]          r_stall;
    logic [15:0]          r_msg_count;
    logic                 r_timeout;

    logic [N_SRC-1:0][7:0] w_data;
    logic [SRC_W-1:0]      w_k;
    logic [SRC_W-1:0]      w_win;
    logic                  w_found;
    logic                  w_owner_req;
    logic                  w_owner_last;
    logic                  w_xfer;

    assign w_data       = i_data;
    assign w_owner_req  = i_req[r_gidx];
    assign w_owner_last = i_last[r_gidx];
    assign w_xfer       = (r_state == SEND) && w_owner_req && i_cts;

    // Search starts one past the previous owner, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            w_k = SRC_W'((int'(r_last_winner) + i) % N_SRC);
            if (!w_found && i_req[w_k]) begin
                w_found = 1'b1;
                w_win   = w_k;
            end
        end
    end

    // Zero-latency pass-through of the owner's byte stream.
    always_comb begin
        o_grant = '0;
        o_cts   = '0;
        o_req   = 1'b0;
        o_data  = '0;
        if (r_state == SEND) begin
            o_grant[r_gidx] = 1'b1;
            o_req           = w_owner_req;
            o_data          = w_data[r_gidx];
            o_cts[r_gidx]   = w_owner_req && i_cts;
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_timeout   = r_timeout;
    assign o_msg_count = r_msg_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_gidx        <= '0;
            r_last_winner <= SRC_W'(N_SRC - 1);
            r_stall       <= '0;
            r_msg_count   <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_idle && w_found) begin
                        r_gidx  <= w_win;
                        r_stall <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        r_stall <= '0;
                        if (w_owner_last) begin
                            r_msg_count   <= r_msg_count + 16'd1;
                            r_last_winner <= r_gidx;
                            r_state       <= HOLD;
                        end
                    end else if (!w_owner_req) begin
                        // Backpressure (req high, cts low) leaves the stall count alone.
                        if (r_stall >= STALL_MAX) begin
                            r_timeout     <= 1'b1;
                            r_last_winner <= r_gidx;
                            r_state       <= HOLD;
                        end else begin
                            r_stall <= r_stall + 16'd1;
                        end
                    end
                end
                HOLD:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
